// File: rtl/pipe_mux.sv
// pipe_mux: registered N:1 channel select with valid/ready handshake and a one-entry skid buffer.
// Optional sel_err output is built when PIPE_MUX_SEL_CHECK_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | main register invalid, skid empty
// ST_ONE   | main register valid, skid empty
// ST_FULL  | main and skid valid, upstream stalled
module pipe_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef PIPE_MUX_SEL_CHECK_EN
    ,
    output logic                    sel_err
`endif
);

    if (SEL_W != $clog2(NUM_IN)) begin : g_bad_sel_w
        $error("pipe_mux: SEL_W must equal $clog2(NUM_IN)");
    end
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("pipe_mux: NUM_IN must be in 2..16");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_nxt;
    logic [WIDTH-1:0]   main_data_q, skid_data_q;
    logic [SEL_W-1:0]   main_sel_q, skid_sel_q;
    logic               in_ready_q;
    logic [WIDTH-1:0]   mux_data;
    logic               accept, consume;
    logic               load_main_in, load_main_skid, load_skid;

    // Unmatched (out-of-range) selects fall through to zero.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) mux_data = in_data[k*WIDTH +: WIDTH];
        end
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_nxt      = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt    = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_FULL;
                        load_skid = 1'b1;
                    end else if (consume) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        state_nxt      = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // in_ready is registered so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            state_q    <= state_nxt;
            in_ready_q <= (state_nxt != ST_FULL);
            if (load_main_in) begin
                main_data_q <= mux_data;
                main_sel_q  <= sel;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_sel_q  <= skid_sel_q;
            end
            if (load_skid) begin
                skid_data_q <= mux_data;
                skid_sel_q  <= sel;
            end else if (flush || load_main_skid) begin
                skid_data_q <= '0;
                skid_sel_q  <= '0;
            end
        end
    end

`ifdef PIPE_MUX_SEL_CHECK_EN
    logic sel_oob;
    logic sel_err_q;

    always_comb begin
        sel_oob = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) sel_oob = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_err_q <= 1'b0;
        end else if (flush) begin
            sel_err_q <= 1'b0;
        end else if (accept && sel_oob) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_pipe_mux.sv
// Directed bench for pipe_mux: scoreboard on a 4-channel instance plus a 3-channel
// instance for out-of-range selects (sel_err checked when PIPE_MUX_SEL_CHECK_EN is defined).
module tb_pipe_mux;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic [95:0]  in_data3;
    logic [1:0]   sel;
    logic         in_valid, flush, out_ready;
    logic         in_ready, out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         in_ready3, out_valid3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
`ifdef PIPE_MUX_SEL_CHECK_EN
    logic         sel_err, sel_err3;
`endif

    logic [31:0]  chan [4];
    ent_t         q[$];
    ent_t         e;
    int           n_chk  = 0;
    int           n_pass = 0;
    int           n_pop  = 0;
    int           pop_mark;

    always #5 clk = ~clk;

    assign in_data3 = in_data[95:0];

    pipe_mux #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef PIPE_MUX_SEL_CHECK_EN
        , .sel_err(sel_err)
`endif
    );

    pipe_mux #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready3), .flush(flush), .out_data(out_data3), .out_sel(out_sel3),
        .out_valid(out_valid3), .out_ready(out_ready)
`ifdef PIPE_MUX_SEL_CHECK_EN
        , .sel_err(sel_err3)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Samples at negedge: pop on consume, push on accept, discard everything on flush.
    task automatic cyc();
        @(negedge clk);
        if (out_valid && out_ready) begin
            check("sb_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_pop++;
                check("sb_data", 64'(out_data), 64'(e.d));
                check("sb_sel", 64'(out_sel), 64'(e.s));
            end
        end
        if (flush) q.delete();
        else if (in_valid && in_ready) q.push_back('{d: chan[sel], s: sel});
        @(posedge clk);
        #1;
    endtask

    initial begin
        chan[0] = 32'h11111111; chan[1] = 32'h22222222;
        chan[2] = 32'h33333333; chan[3] = 32'h44444444;
        in_data = {chan[3], chan[2], chan[1], chan[0]};
        rst = 1'b1; sel = 2'd0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sel", 64'(out_sel), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // basic select
        out_ready = 1'b1; sel = 2'd2; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_data", 64'(out_data), 64'h33333333);
        check("basic_sel", 64'(out_sel), 64'd2);
        cyc();
        check("basic_valid_drop", 64'(out_valid), 64'd0);

        // streaming at full rate
        pop_mark = n_pop;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); in_valid = 1'b1;
            check("stream_in_ready", 64'(in_ready), 64'd1);
            cyc();
            check("stream_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        cyc();
        check("stream_count", 64'(n_pop - pop_mark), 64'd4);
        check("stream_empty", 64'(out_valid), 64'd0);

        // back-pressure into the skid buffer
        out_ready = 1'b0; sel = 2'd1; in_valid = 1'b1;
        cyc();
        check("skid_ready_one", 64'(in_ready), 64'd1);
        sel = 2'd3;
        cyc();
        check("skid_ready_full", 64'(in_ready), 64'd0);
        check("skid_hold_data", 64'(out_data), 64'h22222222);
        sel = 2'd0;
        cyc();
        in_valid = 1'b0;
        check("skid_hold_stable", 64'(out_data), 64'h22222222);
        check("skid_still_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        cyc();
        check("skid_drain_data", 64'(out_data), 64'h44444444);
        check("skid_ready_back", 64'(in_ready), 64'd1);
        cyc();
        check("skid_drained", 64'(out_valid), 64'd0);

        // flush from FULL with a simultaneous offer
        out_ready = 1'b0; sel = 2'd1; in_valid = 1'b1;
        cyc();
        sel = 2'd2;
        cyc();
        sel = 2'd0; flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_full_valid", 64'(out_valid), 64'd0);
        check("flush_full_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        cyc();
        check("flush_full_nodata", 64'(out_valid), 64'd0);

        // flush from ONE wins over an accepted offer
        out_ready = 1'b0; sel = 2'd3; in_valid = 1'b1;
        cyc();
        sel = 2'd0; flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_one_valid", 64'(out_valid), 64'd0);
        check("flush_one_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        cyc();
        check("flush_one_nodata", 64'(out_valid), 64'd0);

        // asynchronous reset while FULL
        out_ready = 1'b0; sel = 2'd2; in_valid = 1'b1;
        cyc();
        sel = 2'd3;
        cyc();
        in_valid = 1'b0;
        check("prerst_full", 64'(in_ready), 64'd0);
        #3 rst = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1; sel = 2'd1; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_data", 64'(out_data), 64'h22222222);
        cyc();

        // out-of-range select on the 3-channel instance
        sel = 2'd3; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("oob_valid", 64'(out_valid3), 64'd1);
        check("oob_data", 64'(out_data3), 64'd0);
        check("oob_sel", 64'(out_sel3), 64'd3);
`ifdef PIPE_MUX_SEL_CHECK_EN
        check("oob_err_set", 64'(sel_err3), 64'd1);
        check("oob_err_4ch", 64'(sel_err), 64'd0);
`endif
        sel = 2'd0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("oob_next_data", 64'(out_data3), 64'h11111111);
`ifdef PIPE_MUX_SEL_CHECK_EN
        check("oob_err_sticky", 64'(sel_err3), 64'd1);
`endif
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
`ifdef PIPE_MUX_SEL_CHECK_EN
        check("oob_err_flush", 64'(sel_err3), 64'd0);
`endif
        check("oob_empty", 64'(out_valid3), 64'd0);

        check("sb_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
